// File: rtl/ctrl_pipe_reg.sv
// ctrl_pipe_reg: DEPTH-stage control-word pipeline with stall, flush, occupancy and saturating stall counter
module ctrl_pipe_reg #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int CW = 16,
  localparam int OW = $clog2(DEPTH+1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] ctrl_in,
  input  logic             valid_in,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] ctrl_out,
  output logic             valid_out,
  output logic [OW-1:0]    occupancy,
  output logic [CW-1:0]    stall_cnt
);
  logic [DEPTH-1:0] stageVld;
  logic [WIDTH-1:0] stageCtl [DEPTH];
  logic [OW-1:0]    occNext;
  assign ctrl_out  = stageCtl[DEPTH-1];
  assign valid_out = stageVld[DEPTH-1];
  // a shift gains the incoming valid word and loses the one leaving the last stage
  always_comb occNext = occupancy + OW'(valid_in) - OW'(stageVld[DEPTH-1]);
  // stages: reset/flush empty everything, stall freezes, otherwise shift; invalid input enters as a bubble
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      stageVld <= '0;
      for (int k = 0; k < DEPTH; k++) stageCtl[k] <= NOP_VALUE;
      occupancy <= '0;
    end else if (!stall) begin
      stageVld[0] <= valid_in;
      stageCtl[0] <= valid_in ? ctrl_in : NOP_VALUE;
      for (int k = 1; k < DEPTH; k++) begin
        stageVld[k] <= stageVld[k-1];
        stageCtl[k] <= stageCtl[k-1];
      end
      occupancy <= occNext;
    end
  end
  // stall counter saturates at all-ones and ignores flush-cycle stalls
  always_ff @(posedge CLK) begin
    if (RST) stall_cnt <= '0;
    else if (stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// tb_ctrl_pipe_reg: random and directed checks of ctrl_pipe_reg (DEPTH=3 and DEPTH=1) against a queue model
module tb_ctrl_pipe_reg;
  logic CLK = 0, RST = 0, valid_in = 0, stall = 0, flush = 0;
  logic [2:0] ctrl_in = '0;
  logic [2:0] ctrlOut3, ctrlOut1;
  logic validOut3, validOut1;
  logic [1:0] occ3;
  logic [0:0] occ1;
  logic [3:0] sc3, sc1;
  int nCmp = 0, nBad = 0, sc = 0;
  bit live = 0;
  logic [3:0] q3[$], q1[$];

  always #5 CLK = ~CLK;

  ctrl_pipe_reg #(.WIDTH(3), .DEPTH(3), .NOP_VALUE(3'b000), .CW(4)) dut3 (
    .CLK(CLK), .RST(RST), .ctrl_in(ctrl_in), .valid_in(valid_in), .stall(stall), .flush(flush),
    .ctrl_out(ctrlOut3), .valid_out(validOut3), .occupancy(occ3), .stall_cnt(sc3));

  ctrl_pipe_reg #(.WIDTH(3), .DEPTH(1), .NOP_VALUE(3'b000), .CW(4)) dut1 (
    .CLK(CLK), .RST(RST), .ctrl_in(ctrl_in), .valid_in(valid_in), .stall(stall), .flush(flush),
    .ctrl_out(ctrlOut1), .valid_out(validOut1), .occupancy(occ1), .stall_cnt(sc1));

  task automatic chk(input string tag, input int got, input int exp);
    nCmp++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int countValid(input logic [3:0] q[$]);
    int n = 0;
    foreach (q[i]) n += int'(q[i][3]);
    return n;
  endfunction

  task automatic checkAll();
    chk("ctrl3", int'(ctrlOut3), int'(q3[2][2:0]));
    chk("valid3", int'(validOut3), int'(q3[2][3]));
    chk("occ3", int'(occ3), countValid(q3));
    chk("sc3", int'(sc3), sc);
    chk("ctrl1", int'(ctrlOut1), int'(q1[0][2:0]));
    chk("valid1", int'(validOut1), int'(q1[0][3]));
    chk("occ1", int'(occ1), countValid(q1));
    chk("sc1", int'(sc1), sc);
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic s, input logic f, input logic r);
    logic [3:0] e;
    valid_in = v; ctrl_in = c; stall = s; flush = f; RST = r;
    @(posedge CLK);
    if (r) begin
      q3 = '{4'h0, 4'h0, 4'h0}; q1 = '{4'h0}; sc = 0; live = 1;
    end else if (f) begin
      q3 = '{4'h0, 4'h0, 4'h0}; q1 = '{4'h0};
    end else if (s) begin
      sc = (sc == 15) ? 15 : sc + 1;
    end else begin
      e = v ? {1'b1, c} : 4'h0;
      q3.push_front(e); void'(q3.pop_back());
      q1.push_front(e); void'(q1.pop_back());
    end
    #1;
    if (live) checkAll();
  endtask

  initial begin
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 3'(i + 1), 0, 0, 0);
    step(1, 3'b111, 1, 1, 1);
    chk("rst_ctrl", int'(ctrlOut3), 0);
    chk("rst_occ", int'(occ3), 0);
    step(1, 3'b101, 0, 0, 0);
    step(1, 3'b110, 0, 0, 0);
    step(1, 3'b011, 0, 0, 0);
    chk("lat_e3", int'(ctrlOut3), 5);
    step(1, 3'b010, 0, 0, 0);
    chk("lat_e4", int'(ctrlOut3), 6);
    step(0, 3'b111, 0, 0, 0);
    chk("lat_e5", int'(ctrlOut3), 3);
    chk("lat_occ5", int'(occ3), 2);
    step(1, 3'b001, 0, 0, 0);
    step(1, 3'b100, 0, 0, 0);
    chk("bubble_ctrl", int'(ctrlOut3), 0);
    chk("bubble_valid", int'(validOut3), 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 3'(i + 4), 0, 0, 0);
    step(1, 3'b111, 1, 0, 0);
    step(0, 3'b000, 1, 0, 0);
    chk("stall_hold", int'(ctrlOut3), 4);
    chk("stall_cnt2", int'(sc3), 2);
    step(1, 3'b111, 1, 1, 0);
    chk("flush_occ", int'(occ3), 0);
    chk("flush_sc", int'(sc3), 2);
    for (int i = 0; i < 20; i++) step(1, 3'(i), 1, 0, 0);
    chk("sat", int'(sc3), 15);
    step(1, 3'b011, 1, 0, 1);
    for (int i = 0; i < 400; i++) begin
      logic s, f, r;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 15) == 0);
      r = ($urandom_range(0, 63) == 0);
      step(1'($urandom_range(0, 1)), 3'($urandom), s, f, r);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
